// File: rtl/rpn_stack_calc.sv
// rpn_stack_calc: parametrised Reverse Polish Notation calculator core.
// Tokens arrive on a stb/ack input handshake. Operands are pushed onto an internal stack, and
// opcodes operate on it. Results and errors leave on a stb/ack output handshake.
// Optional feature macro: RPN_MUL_EN enables opcode 2 (MUL). Without it, opcode 2 is illegal.
module rpn_stack_calc #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       input_stb,
  input  logic [WIDTH-1:0]           input_data,
  input  logic                       is_input_operator,
  output logic                       input_ack,
  output logic                       output_stb,
  output logic [WIDTH-1:0]           output_data,
  output logic                       output_err,
  input  logic                       output_ack,
  output logic [$clog2(DEPTH+1)-1:0] depth
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam logic [DW-1:0] DepthMax = DW'(DEPTH);

  localparam logic [3:0] OpAdd   = 4'd0;
  localparam logic [3:0] OpSub   = 4'd1;
`ifdef RPN_MUL_EN
  localparam logic [3:0] OpMul   = 4'd2;
`endif
  localparam logic [3:0] OpAnd   = 4'd3;
  localparam logic [3:0] OpOr    = 4'd4;
  localparam logic [3:0] OpXor   = 4'd5;
  localparam logic [3:0] OpDup   = 4'd6;
  localparam logic [3:0] OpSwap  = 4'd7;
  localparam logic [3:0] OpDrop  = 4'd8;
  localparam logic [3:0] OpPeek  = 4'd9;
  localparam logic [3:0] OpClear = 4'd10;

  typedef enum logic [1:0] {StIdle, StExec, StOut} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  tok_q;
  logic              is_op_q;
  logic              ack_q;
  logic              stb_q;
  logic              err_q;
  logic [WIDTH-1:0]  data_q;
  logic [DW-1:0]     depth_q;
  logic [WIDTH-1:0]  stack_q [DEPTH];

  logic [IW-1:0]     tos_idx, nos_idx, push_idx;
  logic [WIDTH-1:0]  tos, nos, alu;
  logic              has1, has2, full, bin_op;
  logic [3:0]        opcode;
  logic              ex_out, ex_err, ex_fire;
  logic [WIDTH-1:0]  ex_data;
  logic [DW-1:0]     depth_d;
  logic              wr0_en, wr1_en;
  logic [IW-1:0]     wr0_idx, wr1_idx;
  logic [WIDTH-1:0]  wr0_data, wr1_data;

  assign input_ack   = ack_q;
  assign output_stb  = stb_q;
  assign output_data = data_q;
  assign output_err  = err_q;
  assign depth       = depth_q;

  // The first EXEC cycle is spent in the ack pulse, so execution happens on the second.
  assign ex_fire = (state_q == StExec) && !ack_q;

  // Decode the latched token into stack writes, new depth and the result to present.
  always_comb begin
    tos_idx  = IW'(depth_q - DW'(1));
    nos_idx  = IW'(depth_q - DW'(2));
    push_idx = IW'(depth_q);
    tos      = stack_q[tos_idx];
    nos      = stack_q[nos_idx];
    has1     = depth_q >= DW'(1);
    has2     = depth_q >= DW'(2);
    full     = depth_q == DepthMax;
    opcode   = tok_q[3:0];

    bin_op = 1'b1;
    alu    = '0;
    case (opcode)
      OpAdd:   alu = nos + tos;
      OpSub:   alu = nos - tos;
`ifdef RPN_MUL_EN
      OpMul:   alu = nos * tos;
`endif
      OpAnd:   alu = nos & tos;
      OpOr:    alu = nos | tos;
      OpXor:   alu = nos ^ tos;
      default: bin_op = 1'b0;
    endcase

    ex_out   = 1'b1;
    ex_err   = 1'b0;
    ex_data  = '0;
    depth_d  = depth_q;
    wr0_en   = 1'b0;
    wr0_idx  = push_idx;
    wr0_data = '0;
    wr1_en   = 1'b0;
    wr1_idx  = nos_idx;
    wr1_data = '0;

    if (!is_op_q) begin
      if (full) begin
        ex_err = 1'b1;
      end else begin
        ex_out   = 1'b0;
        wr0_en   = 1'b1;
        wr0_data = tok_q;
        depth_d  = depth_q + DW'(1);
      end
    end else if (bin_op) begin
      if (!has2) begin
        ex_err = 1'b1;
      end else begin
        wr0_en   = 1'b1;
        wr0_idx  = nos_idx;
        wr0_data = alu;
        depth_d  = depth_q - DW'(1);
        ex_data  = alu;
      end
    end else begin
      case (opcode)
        OpDup: begin
          if (!has1 || full) begin
            ex_err = 1'b1;
          end else begin
            wr0_en   = 1'b1;
            wr0_data = tos;
            depth_d  = depth_q + DW'(1);
            ex_data  = tos;
          end
        end
        OpSwap: begin
          if (!has2) begin
            ex_err = 1'b1;
          end else begin
            wr0_en   = 1'b1;
            wr0_idx  = tos_idx;
            wr0_data = nos;
            wr1_en   = 1'b1;
            wr1_data = tos;
            ex_data  = nos;
          end
        end
        OpDrop: begin
          if (!has1) begin
            ex_err = 1'b1;
          end else begin
            depth_d = depth_q - DW'(1);
            ex_data = has2 ? nos : '0;
          end
        end
        OpPeek: begin
          if (!has1) ex_err = 1'b1;
          else       ex_data = tos;
        end
        OpClear: depth_d = '0;
        default: ex_err = 1'b1;
      endcase
    end
  end

  // Stack storage; contents need no reset because depth gates every read.
  always_ff @(posedge clk) begin
    if (!rst && ex_fire) begin
      if (wr0_en) stack_q[wr0_idx] <= wr0_data;
      if (wr1_en) stack_q[wr1_idx] <= wr1_data;
    end
  end

  // Control FSM with registered handshake outputs, depth and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tok_q   <= '0;
      is_op_q <= 1'b0;
      ack_q   <= 1'b0;
      stb_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      depth_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (input_stb) begin
            tok_q   <= input_data;
            is_op_q <= is_input_operator;
            ack_q   <= 1'b1;
            state_q <= StExec;
          end
        end
        StExec: begin
          if (ack_q) begin
            ack_q <= 1'b0;
          end else begin
            depth_q <= depth_d;
            if (ex_out) begin
              stb_q   <= 1'b1;
              data_q  <= ex_data;
              err_q   <= ex_err;
              state_q <= StOut;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StOut: begin
          if (output_ack) begin
            stb_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Self-checking bench for rpn_stack_calc (WIDTH=8, DEPTH=4): directed cases then random tokens
// compared against a queue-based stack model.
module tb_rpn_stack_calc;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int DW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          input_stb;
  logic [W-1:0]  input_data;
  logic          is_input_operator;
  logic          input_ack;
  logic          output_stb;
  logic [W-1:0]  output_data;
  logic          output_err;
  logic          output_ack;
  logic [DW-1:0] depth;

  int n_checks = 0;
  int n_pass   = 0;
  int stk[$];
  logic [W-1:0] obs_data;
  logic         obs_err;

  rpn_stack_calc #(.WIDTH(W), .DEPTH(D)) dut (
    .clk               (clk),
    .rst               (rst),
    .input_stb         (input_stb),
    .input_data        (input_data),
    .is_input_operator (is_input_operator),
    .input_ack         (input_ack),
    .output_stb        (output_stb),
    .output_data       (output_data),
    .output_err        (output_err),
    .output_ack        (output_ack),
    .depth             (depth)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Reference model: applies one token to the queue and returns the expected response.
  function automatic void model(input bit is_op, input int val,
                                output bit out, output bit err, output int data);
    int mask = (1 << W) - 1;
    int op   = val & 15;
    int a, b, r;
    bit mul_ok;
`ifdef RPN_MUL_EN
    mul_ok = 1'b1;
`else
    mul_ok = 1'b0;
`endif
    out = 1'b1;
    err = 1'b0;
    if (!is_op) begin
      if (stk.size() == D) err = 1'b1;
      else begin stk.push_back(val & mask); out = 1'b0; end
    end else if (op <= 5 && (op != 2 || mul_ok)) begin
      if (stk.size() < 2) err = 1'b1;
      else begin
        a = stk.pop_back();
        b = stk.pop_back();
        case (op)
          0: r = b + a;
          1: r = b - a;
          2: r = b * a;
          3: r = b & a;
          4: r = b | a;
          default: r = b ^ a;
        endcase
        stk.push_back(r & mask);
      end
    end else begin
      case (op)
        6:  if (stk.size() < 1 || stk.size() == D) err = 1'b1;
            else stk.push_back(stk[$]);
        7:  if (stk.size() < 2) err = 1'b1;
            else begin a = stk.pop_back(); b = stk.pop_back(); stk.push_back(a); stk.push_back(b); end
        8:  if (stk.size() < 1) err = 1'b1; else void'(stk.pop_back());
        9:  if (stk.size() < 1) err = 1'b1;
        10: stk.delete();
        default: err = 1'b1;
      endcase
    end
    data = (err || stk.size() == 0) ? 0 : stk[$];
  endfunction

  // Send one token and follow it through ack, execution and (if any) the output handshake.
  task automatic token(input bit is_op, input int val, input int stall, input bit rst_mid);
    bit eo, ee, got;
    int ed;
    model(is_op, val, eo, ee, ed);
    input_stb         = 1'b1;
    input_data        = W'(val);
    is_input_operator = is_op;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (input_ack) got = 1'b1;
    end
    input_stb = 1'b0;
    check("ack_seen", got, 1);
    if (!got) return;
    @(posedge clk); #1;
    check("ack_pulse", input_ack, 0);
    check("stb_early", output_stb, 0);
    @(posedge clk); #1;
    check("depth", depth, stk.size());
    check("out_stb", output_stb, eo);
    if (!eo) return;
    check("out_data", output_data, ed);
    check("out_err", output_err, ee);
    obs_data = output_data;
    obs_err  = output_err;
    for (int i = 0; i < stall; i++) begin
      input_stb         = 1'($urandom_range(0, 1));
      input_data        = W'($urandom);
      is_input_operator = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("hold_stb", output_stb, 1);
      check("hold_data", output_data, ed);
      check("hold_ack", input_ack, 0);
    end
    input_stb = 1'b0;
    if (rst_mid) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_ack", input_ack, 0);
      check("rst_stb", output_stb, 0);
      check("rst_data", output_data, 0);
      check("rst_err", output_err, 0);
      check("rst_depth", depth, 0);
      stk.delete();
      return;
    end
    output_ack = 1'b1;
    @(posedge clk); #1;
    output_ack = 1'b0;
    @(posedge clk); #1;
    check("stb_drop", output_stb, 0);
  endtask

  initial begin
    rst               = 1'b1;
    input_stb         = 1'b0;
    input_data        = '0;
    is_input_operator = 1'b0;
    output_ack        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_ack", input_ack, 0);
    check("reset_stb", output_stb, 0);
    check("reset_data", output_data, 0);
    check("reset_err", output_err, 0);
    check("reset_depth", depth, 0);

    // Directed scenarios
    token(0, 3, 0, 0); token(0, 4, 0, 0); token(1, 0, 1, 0);
    check("tp_add", obs_data, 7);
    token(1, 10, 0, 0);
    token(0, 5, 0, 0); token(0, 7, 0, 0); token(1, 1, 0, 0);
    check("tp_sub_wrap", obs_data, 8'hFE);
    token(1, 8, 0, 0);
    check("tp_drop_data", obs_data, 0);
    check("tp_drop_err", obs_err, 0);
    token(0, 9, 0, 0); token(1, 0, 0, 0);
    check("tp_underflow", obs_err, 1);
    token(1, 12, 0, 0);
    check("tp_illegal", obs_err, 1);
    token(1, 10, 0, 0);
    for (int i = 1; i <= 5; i++) token(0, i, 0, 0);
    check("tp_overflow_push", obs_err, 1);
    token(1, 9, 0, 0);
    check("tp_peek", obs_data, 4);
    token(1, 6, 0, 0);
    check("tp_dup_full", obs_err, 1);
    token(1, 10, 0, 0);
    token(0, 16, 0, 0); token(0, 17, 0, 0); token(1, 2, 0, 0);
`ifdef RPN_MUL_EN
    check("tp_mul", obs_data, 8'h10);
`else
    check("tp_mul_illegal", obs_err, 1);
`endif
    token(1, 9, 10, 0);
    token(1, 9, 3, 1);

    // Random tokens
    for (int n = 0; n < 300; n++) begin
      bit is_op = 1'($urandom_range(0, 1));
      int val   = is_op ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 255));
      token(is_op, val, int'($urandom_range(0, 3)), ($urandom_range(0, 39) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
